// File: rtl/ddp_hdr_parse_pkg.sv
// Shared definitions for the receive-side DDP header parser: opcodes, DDP
// header field positions and the accumulator control encoding.
package ddp_hdr_parse_pkg;

    localparam int MAX_PIECES  = 4;
    localparam int PIECE_LEN_W = 9;
    localparam int QN_W        = 4;
    localparam int PID_W       = 3;
    localparam int LEN_TOT_W   = MAX_PIECES * PIECE_LEN_W;
    localparam int QN_TOT_W    = MAX_PIECES * QN_W;

    localparam logic [3:0] OP_SEND    = 4'b0000;
    localparam logic [3:0] OP_RCV     = 4'b0001;
    localparam logic [3:0] OP_REQ     = 4'b0011;
    localparam logic [3:0] OP_WR_DONE = 4'b0101;
    localparam logic [3:0] OP_ACK     = 4'b0111;
    localparam logic [3:0] OP_RD_DONE = 4'b1001;

    // DDP header layout: {PID, QN, LEN}
    localparam int PID_HI = 15;
    localparam int PID_LO = 13;
    localparam int QN_HI  = 12;
    localparam int QN_LO  = 9;
    localparam int LEN_HI = 8;
    localparam int LEN_LO = 0;

    localparam int CTRL_SOP = 7;
    localparam int CTRL_EOP = 6;

    localparam logic [PIECE_LEN_W-1:0] REQ_DDP_LEN = 9'd6;
    localparam logic [PIECE_LEN_W-1:0] ACK_DDP_LEN = 9'd4;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } state_e;

    typedef enum logic [1:0] {
        ACC_HOLD,
        ACC_LOAD,
        ACC_APPEND,
        ACC_CLEAR
    } acc_op_e;

    // A zero-length piece is stored as 0 rather than wrapping to all ones.
    function automatic logic [PIECE_LEN_W-1:0] len_m1(input logic [PIECE_LEN_W-1:0] len);
        return (len == '0) ? '0 : len - 9'd1;
    endfunction

endpackage

// File: rtl/ddp_piece_acc.sv
// Per-SEND piece accumulator: expected PID plus packed length and queue-number
// slots. The next-state values are exported so a record can include the piece
// being appended in the same cycle.
module ddp_piece_acc
    import ddp_hdr_parse_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  acc_op_e                op_i,
    input  logic [PID_W-1:0]       pid_i,
    input  logic [PIECE_LEN_W-1:0] len_m1_i,
    input  logic [QN_W-1:0]        qn_i,
    output logic [PID_W-1:0]       exp_pid_o,
    output logic [LEN_TOT_W-1:0]   len_o,
    output logic [LEN_TOT_W-1:0]   len_nxt_o,
    output logic [QN_TOT_W-1:0]    qn_o,
    output logic [QN_TOT_W-1:0]    qn_nxt_o
);

    logic [PID_W-1:0]     exp_pid_q, exp_pid_d;
    logic [LEN_TOT_W-1:0] len_q, len_d;
    logic [QN_TOT_W-1:0]  qn_q, qn_d;

    always_comb begin
        exp_pid_d = exp_pid_q;
        len_d     = len_q;
        qn_d      = qn_q;
        case (op_i)
            ACC_LOAD: begin
                len_d                         = '0;
                len_d[PIECE_LEN_W-1:0]        = len_m1_i;
                qn_d                          = '0;
                qn_d[QN_TOT_W-1 -: QN_W]      = qn_i;
                exp_pid_d                     = 3'd1;
            end
            ACC_APPEND: begin
                for (int k = 0; k < MAX_PIECES; k++) begin
                    if (pid_i == 3'(k)) begin
                        len_d[k*PIECE_LEN_W +: PIECE_LEN_W] = len_m1_i;
                        qn_d[QN_TOT_W-1-k*QN_W -: QN_W]     = qn_i;
                    end
                end
                exp_pid_d = exp_pid_q + 3'd1;
            end
            ACC_CLEAR: begin
                len_d     = '0;
                qn_d      = '0;
                exp_pid_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_pid_q <= '0;
            len_q     <= '0;
            qn_q      <= '0;
        end else begin
            exp_pid_q <= exp_pid_d;
            len_q     <= len_d;
            qn_q      <= qn_d;
        end
    end

    assign exp_pid_o = exp_pid_q;
    assign len_o     = len_q;
    assign len_nxt_o = len_d;
    assign qn_o      = qn_q;
    assign qn_nxt_o  = qn_d;

endmodule

// File: rtl/ddp_hdr_parse.sv
// Receive-side DDP parser: validates REQ/ACK frames, reassembles multi-piece
// SENDs into one record and pushes records downstream through a one-deep output register.
module ddp_hdr_parse
    import ddp_hdr_parse_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [55:0]          pkt2DdpRdmapHeader,
    input  logic [7:0]           pkt2DdpRdmapCtrl,
    input  logic [15:0]          pkt2DdpDdpHeader,
    input  logic [7:0]           pkt2DdpDdpCtrl,
    input  logic                 pkt2DdpValid,
    output logic                 ddpInReady,
    output logic [55:0]          ddp2RdmapHeader,
    output logic [7:0]           ddp2RdmapCtrl,
    output logic [2:0]           ddp2RdmapNum,
    output logic [LEN_TOT_W-1:0] ddp2RdmapLen,
    output logic [QN_TOT_W-1:0]  ddp2RdmapQN,
    output logic                 ddp2RdmapErr,
    output logic                 ddp2RdmapValid,
    input  logic                 rdmapFull
);

    state_e               state_q, state_d;
    logic [55:0]          hdr_q, hdr_d;
    logic [7:0]           ctrl_q, ctrl_d;
    logic                 zero_err_q, zero_err_d;
    logic                 out_pending_q;
    logic [55:0]          out_hdr_q;
    logic [7:0]           out_ctrl_q;
    logic [2:0]           out_num_q;
    logic [LEN_TOT_W-1:0] out_len_q;
    logic [QN_TOT_W-1:0]  out_qn_q;
    logic                 out_err_q;

    logic                 build;
    logic [55:0]          rec_hdr;
    logic [7:0]           rec_ctrl;
    logic [2:0]           rec_num;
    logic [LEN_TOT_W-1:0] rec_len;
    logic [QN_TOT_W-1:0]  rec_qn;
    logic                 rec_err;

    acc_op_e              acc_op;
    logic [PID_W-1:0]     acc_exp_pid;
    logic [LEN_TOT_W-1:0] acc_len, acc_len_nxt;
    logic [QN_TOT_W-1:0]  acc_qn, acc_qn_nxt;

    logic                   accept;
    logic [3:0]             in_op;
    logic                   in_sop, in_eop, in_len_zero;
    logic [PID_W-1:0]       in_pid;
    logic [QN_W-1:0]        in_qn;
    logic [PIECE_LEN_W-1:0] in_len;
    logic                   unused_ddp_ctrl;

    assign accept          = pkt2DdpValid & ~out_pending_q;
    assign in_op           = pkt2DdpRdmapCtrl[3:0];
    assign in_sop          = pkt2DdpDdpCtrl[CTRL_SOP];
    assign in_eop          = pkt2DdpDdpCtrl[CTRL_EOP];
    assign in_pid          = pkt2DdpDdpHeader[PID_HI:PID_LO];
    assign in_qn           = pkt2DdpDdpHeader[QN_HI:QN_LO];
    assign in_len          = pkt2DdpDdpHeader[LEN_HI:LEN_LO];
    assign in_len_zero     = (in_len == '0);
    assign unused_ddp_ctrl = ^pkt2DdpDdpCtrl[5:0];

    ddp_piece_acc u_acc (
        .clock     (clock),
        .reset     (reset),
        .op_i      (acc_op),
        .pid_i     (in_pid),
        .len_m1_i  (len_m1(in_len)),
        .qn_i      (in_qn),
        .exp_pid_o (acc_exp_pid),
        .len_o     (acc_len),
        .len_nxt_o (acc_len_nxt),
        .qn_o      (acc_qn),
        .qn_nxt_o  (acc_qn_nxt)
    );

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        ctrl_d     = ctrl_q;
        zero_err_d = zero_err_q;
        acc_op     = ACC_HOLD;
        build      = 1'b0;
        rec_hdr    = pkt2DdpRdmapHeader;
        rec_ctrl   = pkt2DdpRdmapCtrl;
        rec_num    = 3'd1;
        rec_len    = '0;
        rec_qn     = '0;
        rec_err    = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    case (in_op)
                        OP_REQ, OP_ACK: begin
                            build   = 1'b1;
                            rec_err = ~(in_sop & in_eop) |
                                      (in_len != ((in_op == OP_REQ) ? REQ_DDP_LEN : ACK_DDP_LEN));
                        end
                        OP_SEND: begin
                            if (in_sop && in_pid == '0) begin
                                acc_op     = ACC_LOAD;
                                hdr_d      = pkt2DdpRdmapHeader;
                                ctrl_d     = pkt2DdpRdmapCtrl;
                                zero_err_d = in_len_zero;
                                if (in_eop) begin
                                    build   = 1'b1;
                                    rec_len = acc_len_nxt;
                                    rec_qn  = acc_qn_nxt;
                                    rec_err = in_len_zero;
                                end else begin
                                    state_d = ST_ACCUM;
                                end
                            end else begin
                                build   = 1'b1;
                                rec_err = 1'b1;
                            end
                        end
                        OP_RCV, OP_WR_DONE, OP_RD_DONE: ;
                        default: ;
                    endcase
                end
                ST_ACCUM: begin
                    rec_hdr  = hdr_q;
                    rec_ctrl = ctrl_q;
                    build    = in_eop;
                    if (in_op == OP_SEND && !in_sop && in_pid == acc_exp_pid &&
                        acc_exp_pid < 3'(MAX_PIECES)) begin
                        acc_op     = ACC_APPEND;
                        zero_err_d = zero_err_q | in_len_zero;
                        rec_num    = in_pid + 3'd1;
                        rec_len    = acc_len_nxt;
                        rec_qn     = acc_qn_nxt;
                        rec_err    = zero_err_q | in_len_zero;
                        if (in_eop) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Offending frame is swallowed; report what was gathered.
                        build      = 1'b1;
                        acc_op     = ACC_CLEAR;
                        zero_err_d = 1'b0;
                        rec_num    = acc_exp_pid;
                        rec_len    = acc_len;
                        rec_qn     = acc_qn;
                        rec_err    = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            hdr_q         <= '0;
            ctrl_q        <= '0;
            zero_err_q    <= 1'b0;
            out_pending_q <= 1'b0;
            out_hdr_q     <= '0;
            out_ctrl_q    <= '0;
            out_num_q     <= '0;
            out_len_q     <= '0;
            out_qn_q      <= '0;
            out_err_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            ctrl_q     <= ctrl_d;
            zero_err_q <= zero_err_d;
            if (build) begin
                out_pending_q <= 1'b1;
                out_hdr_q     <= rec_hdr;
                out_ctrl_q    <= rec_ctrl;
                out_num_q     <= rec_num;
                out_len_q     <= rec_len;
                out_qn_q      <= rec_qn;
                out_err_q     <= rec_err;
            end else if (out_pending_q && !rdmapFull) begin
                out_pending_q <= 1'b0;
            end
        end
    end

    assign ddpInReady      = ~out_pending_q;
    assign ddp2RdmapValid  = out_pending_q & ~rdmapFull;
    assign ddp2RdmapHeader = out_hdr_q;
    assign ddp2RdmapCtrl   = out_ctrl_q;
    assign ddp2RdmapNum    = out_num_q;
    assign ddp2RdmapLen    = out_len_q;
    assign ddp2RdmapQN     = out_qn_q;
    assign ddp2RdmapErr    = out_err_q;

endmodule

// File: tb/tb_ddp_hdr_parse.sv
// Bench for ddp_hdr_parse: directed scenarios with literal expectations plus
// randomized frame streams checked each cycle against a record-level model.
module tb_ddp_hdr_parse;

    logic        clk;
    logic        rst_n;
    logic [55:0] pkt2DdpRdmapHeader;
    logic [7:0]  pkt2DdpRdmapCtrl;
    logic [15:0] pkt2DdpDdpHeader;
    logic [7:0]  pkt2DdpDdpCtrl;
    logic        pkt2DdpValid;
    logic        ddpInReady;
    logic [55:0] ddp2RdmapHeader;
    logic [7:0]  ddp2RdmapCtrl;
    logic [2:0]  ddp2RdmapNum;
    logic [35:0] ddp2RdmapLen;
    logic [15:0] ddp2RdmapQN;
    logic        ddp2RdmapErr;
    logic        ddp2RdmapValid;
    logic        rdmapFull;

    ddp_hdr_parse dut (
        .clock              (clk),
        .reset              (rst_n),
        .pkt2DdpRdmapHeader (pkt2DdpRdmapHeader),
        .pkt2DdpRdmapCtrl   (pkt2DdpRdmapCtrl),
        .pkt2DdpDdpHeader   (pkt2DdpDdpHeader),
        .pkt2DdpDdpCtrl     (pkt2DdpDdpCtrl),
        .pkt2DdpValid       (pkt2DdpValid),
        .ddpInReady         (ddpInReady),
        .ddp2RdmapHeader    (ddp2RdmapHeader),
        .ddp2RdmapCtrl      (ddp2RdmapCtrl),
        .ddp2RdmapNum       (ddp2RdmapNum),
        .ddp2RdmapLen       (ddp2RdmapLen),
        .ddp2RdmapQN        (ddp2RdmapQN),
        .ddp2RdmapErr       (ddp2RdmapErr),
        .ddp2RdmapValid     (ddp2RdmapValid),
        .rdmapFull          (rdmapFull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rnd_full = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [55:0] hdr;
        logic [7:0]  ctrl;
        logic [2:0]  num;
        logic [35:0] len;
        logic [15:0] qn;
        logic        err;
    } rec_t;

    rec_t        expq[$];
    bit          m_in_send;
    int          m_n;
    int          m_lens[4];
    int          m_qns[4];
    bit          m_zerr;
    logic [55:0] m_hdr;
    logic [7:0]  m_ctrl;

    function automatic rec_t mk(input logic [55:0] h, input logic [7:0] c, input int n,
                                input bit use_pieces, input bit e);
        rec_t r;
        r.hdr  = h;
        r.ctrl = c;
        r.num  = 3'(n);
        r.len  = '0;
        r.qn   = '0;
        if (use_pieces) begin
            for (int k = 0; k < n; k++) begin
                r.len = r.len | (36'(m_lens[k]) << (9 * k));
                r.qn  = r.qn  | (16'(m_qns[k]) << (12 - 4 * k));
            end
        end
        r.err = e;
        return r;
    endfunction

    task automatic model_frame();
        int  op   = int'(pkt2DdpRdmapCtrl[3:0]);
        bit  sop  = pkt2DdpDdpCtrl[7];
        bit  eop  = pkt2DdpDdpCtrl[6];
        int  pid  = int'(pkt2DdpDdpHeader[15:13]);
        int  qn   = int'(pkt2DdpDdpHeader[12:9]);
        int  len  = int'(pkt2DdpDdpHeader[8:0]);
        int  lm1  = (len == 0) ? 0 : len - 1;
        if (!m_in_send) begin
            if (op == 3 || op == 7) begin
                expq.push_back(mk(pkt2DdpRdmapHeader, pkt2DdpRdmapCtrl, 1, 1'b0,
                                  !(sop && eop) || len != ((op == 3) ? 6 : 4)));
            end else if (op == 0) begin
                if (sop && pid == 0) begin
                    m_n = 1; m_lens[0] = lm1; m_qns[0] = qn; m_zerr = (len == 0);
                    m_hdr = pkt2DdpRdmapHeader; m_ctrl = pkt2DdpRdmapCtrl;
                    if (eop) expq.push_back(mk(m_hdr, m_ctrl, 1, 1'b1, m_zerr));
                    else     m_in_send = 1'b1;
                end else begin
                    expq.push_back(mk(pkt2DdpRdmapHeader, pkt2DdpRdmapCtrl, 1, 1'b0, 1'b1));
                end
            end
        end else begin
            if (op == 0 && !sop && pid == m_n && m_n < 4) begin
                m_lens[m_n] = lm1; m_qns[m_n] = qn; m_n++;
                m_zerr = m_zerr || (len == 0);
                if (eop) begin
                    expq.push_back(mk(m_hdr, m_ctrl, m_n, 1'b1, m_zerr));
                    m_in_send = 1'b0;
                end
            end else begin
                expq.push_back(mk(m_hdr, m_ctrl, m_n, 1'b1, 1'b1));
                m_in_send = 1'b0;
            end
        end
    endtask

    // Compare process: mid-cycle view of every clock.
    always @(negedge clk) begin
        bit   exp_ready;
        rec_t r;
        if (!rst_n) begin
            expq.delete();
            m_in_send = 1'b0;
            chk("rst_ready", 64'(ddpInReady), 64'(1));
            chk("rst_valid", 64'(ddp2RdmapValid), 64'(0));
            chk("rst_fields", 64'({ddp2RdmapNum, ddp2RdmapLen, ddp2RdmapQN, ddp2RdmapErr}), 64'(0));
            chk("rst_hdr", 64'({ddp2RdmapHeader, ddp2RdmapCtrl}), 64'(0));
        end else begin
            exp_ready = (expq.size() == 0);
            chk("ready", 64'(ddpInReady), 64'(exp_ready));
            chk("valid", 64'(ddp2RdmapValid), 64'(!exp_ready && !rdmapFull));
            if (!exp_ready && !rdmapFull) begin
                r = expq.pop_front();
                chk("rec_hdr", 64'(ddp2RdmapHeader), 64'(r.hdr));
                chk("rec_ctrl", 64'(ddp2RdmapCtrl), 64'(r.ctrl));
                chk("rec_num", 64'(ddp2RdmapNum), 64'(r.num));
                chk("rec_len", 64'(ddp2RdmapLen), 64'(r.len));
                chk("rec_qn", 64'(ddp2RdmapQN), 64'(r.qn));
                chk("rec_err", 64'(ddp2RdmapErr), 64'(r.err));
            end
            if (pkt2DdpValid && exp_ready) model_frame();
        end
    end

    // ---------------- stimulus helpers (phase: posedge + 2) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rnd_full) rdmapFull = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic send(input logic [55:0] h, input logic [3:0] op, input logic sop,
                        input logic eop, input logic [2:0] pid, input logic [3:0] qn,
                        input logic [8:0] len);
        bit acc = 1'b0;
        int n   = 0;
        pkt2DdpRdmapHeader = h;
        pkt2DdpRdmapCtrl   = {4'($urandom_range(0, 15)), op};
        pkt2DdpDdpHeader   = {pid, qn, len};
        pkt2DdpDdpCtrl     = {sop, eop, 6'd0};
        pkt2DdpValid       = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = ddpInReady;
            @(posedge clk);
            #2;
            n++;
            if (rnd_full) rdmapFull = ($urandom_range(0, 2) == 0);
        end
        pkt2DdpValid = 1'b0;
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ddp2RdmapValid && lat < 50);
        if (!ddp2RdmapValid) chk("valid_timeout", 64'(0), 64'(1));
    endtask

    logic [55:0] hh;
    logic [35:0] len4;
    int          lat;
    int          gpid;

    initial begin
        rst_n = 1'b0;
        pkt2DdpRdmapHeader = '0; pkt2DdpRdmapCtrl = '0;
        pkt2DdpDdpHeader = '0; pkt2DdpDdpCtrl = '0;
        pkt2DdpValid = 1'b0; rdmapFull = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // REQ, sop|eop, LEN=6: clean record next cycle
        hh = 56'h11_2233_4455_6677;
        send(hh, 4'b0011, 1, 1, 3'd0, 4'd0, 9'd6);
        wait_valid(lat);
        chk("req_latency", 64'(lat), 64'(1));
        chk("req_num", 64'(ddp2RdmapNum), 64'(1));
        chk("req_len", 64'(ddp2RdmapLen), 64'(0));
        chk("req_err", 64'(ddp2RdmapErr), 64'(0));
        chk("req_hdr", 64'(ddp2RdmapHeader), 64'(hh));
        idle(1);

        // 4-piece SEND
        send(56'hA0, 4'b0000, 1, 0, 3'd0, 4'd1, 9'h10);
        send(56'hA1, 4'b0000, 0, 0, 3'd1, 4'd2, 9'h20);
        send(56'hA2, 4'b0000, 0, 0, 3'd2, 4'd3, 9'h30);
        send(56'hA3, 4'b0000, 0, 1, 3'd3, 4'd4, 9'h40);
        wait_valid(lat);
        len4 = {9'h03F, 9'h02F, 9'h01F, 9'h00F};
        chk("send4_num", 64'(ddp2RdmapNum), 64'(4));
        chk("send4_len", 64'(ddp2RdmapLen), 64'(len4));
        chk("send4_qn", 64'(ddp2RdmapQN), 64'(16'h1234));
        chk("send4_err", 64'(ddp2RdmapErr), 64'(0));
        chk("send4_hdr", 64'(ddp2RdmapHeader), 64'(56'hA0));
        idle(1);

        // PID 0 then 2: error record with one piece, then clean REQ
        send(56'hB0, 4'b0000, 1, 0, 3'd0, 4'd5, 9'h08);
        send(56'hB2, 4'b0000, 0, 1, 3'd2, 4'd6, 9'h08);
        wait_valid(lat);
        chk("skip_num", 64'(ddp2RdmapNum), 64'(1));
        chk("skip_err", 64'(ddp2RdmapErr), 64'(1));
        chk("skip_len", 64'(ddp2RdmapLen), 64'(7));
        idle(1);
        send(56'hC0, 4'b0011, 1, 1, 3'd0, 4'd0, 9'd6);
        wait_valid(lat);
        chk("req2_err", 64'(ddp2RdmapErr), 64'(0));
        idle(1);

        // ACK with wrong length
        send(56'hD0, 4'b0111, 1, 1, 3'd0, 4'd0, 9'd6);
        wait_valid(lat);
        chk("ack_err", 64'(ddp2RdmapErr), 64'(1));
        chk("ack_num", 64'(ddp2RdmapNum), 64'(1));
        idle(1);

        // backpressure: rdmapFull held after a REQ
        rdmapFull = 1'b1;
        send(56'hE0, 4'b0011, 1, 1, 3'd0, 4'd0, 9'd6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_valid", 64'(ddp2RdmapValid), 64'(0));
            chk("full_ready", 64'(ddpInReady), 64'(0));
        end
        @(posedge clk);
        #2;
        rdmapFull = 1'b0;
        @(negedge clk);
        chk("full_release_valid", 64'(ddp2RdmapValid), 64'(1));
        chk("full_release_hdr", 64'(ddp2RdmapHeader), 64'(56'hE0));
        idle(1);

        // reset mid-ACCUM discards the partial record
        send(56'hF0, 4'b0000, 1, 0, 3'd0, 4'd1, 9'h05);
        send(56'hF1, 4'b0000, 0, 0, 3'd1, 4'd2, 9'h05);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(56'hF8, 4'b0000, 1, 1, 3'd0, 4'd9, 9'd8);
        wait_valid(lat);
        chk("post_rst_num", 64'(ddp2RdmapNum), 64'(1));
        chk("post_rst_len", 64'(ddp2RdmapLen), 64'(7));
        chk("post_rst_qn", 64'(ddp2RdmapQN), 64'(16'h9000));
        idle(1);

        // randomized stream
        rnd_full = 1'b1;
        gpid = 0;
        for (int f = 0; f < 1500; f++) begin
            int          r = $urandom_range(0, 99);
            logic [55:0] h = {24'($urandom), 32'($urandom)};
            logic [8:0]  ln = ($urandom_range(0, 19) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            logic [3:0]  others[5] = '{4'h1, 4'h2, 4'h5, 4'h9, 4'hF};
            if (r < 70) begin
                logic [2:0] p  = 3'(gpid);
                logic       s  = (gpid == 0);
                logic       e  = (gpid == 3) || ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 19) == 0) p = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 24) == 0) s = ~s;
                if ($urandom_range(0, 30) == 0) e = 1'b0;
                send(h, 4'b0000, s, e, p, 4'($urandom_range(0, 15)), ln);
                gpid = (e || gpid >= 4) ? 0 : gpid + 1;
            end else if (r < 80) begin
                send(h, 4'b0011, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 3'd0,
                     4'd0, ($urandom_range(0, 4) == 0) ? ln : 9'd6);
                gpid = 0;
            end else if (r < 90) begin
                send(h, 4'b0111, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 3'd0,
                     4'd0, ($urandom_range(0, 4) == 0) ? ln : 9'd4);
                gpid = 0;
            end else begin
                send(h, others[$urandom_range(0, 4)], 1, 1, 3'd0, 4'd0, ln);
            end
            idle($urandom_range(0, 2));
        end
        rnd_full = 1'b0;
        rdmapFull = 1'b0;
        idle(10);
        chk("drain", 64'(expq.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
